img_stream_ctrl: RTL

IMG_STREAM_CTRL -- requirements
Module: img_stream_ctrl

---
 rtl/img_stream_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/img_stream_ctrl.sv
// img_stream_ctrl: snapshots a 7x7 binary image on start, streams it pixel by
// pixel over a valid/ready handshake, then waits (bounded) for the classifier
// result and latches it.
module img_stream_ctrl #(
  parameter int NPIX    = 49,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NPIX-1:0] img,
  output logic            pix_data,
  output logic [5:0]      pix_idx,
  output logic            pix_valid,
  input  logic            pix_ready,
  input  logic            res_valid,
  input  logic [3:0]      res_class,
  output logic            busy,
  output logic            done,
  output logic [3:0]      class_out,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NPIX - 1);
  localparam logic [9:0] TMO      = 10'(TIMEOUT);

  state_t          state, nstate;
  logic [NPIX-1:0] snap;
  logic [5:0]      cnt;
  logic [9:0]      timer;
  logic            xfer;
  logic            accept;

  assign accept   = (state == IDLE) && start;
  assign xfer     = pix_valid && pix_ready;
  assign pix_idx  = cnt;
  assign pix_data = snap[cnt];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state and state-decoded outputs; result beats timeout on a tie
  always_comb begin
    nstate    = state;
    busy      = 1'b1;
    done      = 1'b0;
    pix_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nstate = STREAM;
      end
      STREAM: begin
        pix_valid = 1'b1;
        if (pix_ready && cnt == LAST_IDX) nstate = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid)         nstate = DONE;
        else if (timer == TMO) nstate = IDLE;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Frame snapshot and pixel counter; counter saturates on the last pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
      cnt  <= '0;
    end else if (accept) begin
      snap <= img;
      cnt  <= '0;
    end else if (xfer && cnt != LAST_IDX) begin
      cnt  <= cnt + 6'd1;
    end
  end

  // Result wait timer, only runs inside WAIT_RES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 timer <= '0;
    else if (state != WAIT_RES) timer <= '0;
    else                        timer <= timer + 10'd1;
  end

  // Result latch and sticky timeout flag (cleared by the next accepted start)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      class_out <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      err       <= 1'b0;
    end else if (state == WAIT_RES) begin
      if (res_valid)         class_out <= res_class;
      else if (timer == TMO) err       <= 1'b1;
    end
  end

endmodule
